csa_share_sched: RTL and testbench

//  Round-robin scheduler sharing one 25-bit carry-select adder (UBCSe_24_0_24_0) among NREQ requesters.

---
 rtl/csa_sched_pkg.sv | 18 +
 rtl/csa_share_sched_if.sv | 36 +++
 rtl/UBCSe_24_0_24_0.sv | 41 ++++
 rtl/rr_arb_nreq.sv | 52 +++++
 rtl/csa_share_sched.sv | 116 +++++++++++
 tb/tb_csa_share_sched.sv | 285 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/csa_sched_pkg.sv
// ---------------------------------------------------------------------------
// csa_sched_pkg
// Shared widths and types for the shared carry-select adder scheduler.
//   OPW       operand width (25 bits, unsigned)
//   SUMW      result width (26 bits, bit 25 = carry out)
//   op_pair_t one requester's operand pair {x, y}
// ---------------------------------------------------------------------------
package csa_sched_pkg;

    localparam int OPW  = 25;
    localparam int SUMW = 26;

    typedef struct packed {
        logic [OPW-1:0] x;
        logic [OPW-1:0] y;
    } op_pair_t;

endpackage

// File: rtl/csa_share_sched_if.sv
// ---------------------------------------------------------------------------
// csa_share_sched_if
// Request and result handshake bundle of csa_share_sched.
//   req_valid / req_ready   per-requester valid/ready (NREQ bits each)
//   req_x / req_y           packed operands, requester i in [25i+24:25i]
//   out_valid / out_ready   result handshake
//   out_sum / out_id        26-bit sum and the ID of the requester it belongs to
// master = requester/consumer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface csa_share_sched_if
    import csa_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) ();

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_x;
    logic [NREQ*OPW-1:0] req_y;
    logic                out_valid;
    logic                out_ready;
    logic [SUMW-1:0]     out_sum;
    logic [IDW-1:0]      out_id;

    modport master (
        output req_valid, req_x, req_y, out_ready,
        input  req_ready, out_valid, out_sum, out_id
    );

    modport slave (
        input  req_valid, req_x, req_y, out_ready,
        output req_ready, out_valid, out_sum, out_id
    );

endinterface

// File: rtl/UBCSe_24_0_24_0.sv
// ---------------------------------------------------------------------------
// UBCSe_24_0_24_0
// Unsigned 25 + 25 -> 26 bit carry-select adder, purely combinational.
// The operands are split into five 5-bit blocks; each block precomputes its
// sum for carry-in 0 and 1 and the incoming block carry picks one.
//   i_x, i_y   25-bit unsigned operands
//   o_sum      26-bit result, bit 25 = carry out
// ---------------------------------------------------------------------------
module UBCSe_24_0_24_0
    import csa_sched_pkg::*;
(
    input  logic [OPW-1:0]  i_x,
    input  logic [OPW-1:0]  i_y,
    output logic [SUMW-1:0] o_sum
);

    localparam int BLKW = 5;
    localparam int NBLK = OPW / BLKW;

    // w_carry[gi] is the carry into block gi; block 0 has no carry in.
    logic [NBLK:0] w_carry;

    assign w_carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
            logic [BLKW:0] w_s0;
            logic [BLKW:0] w_s1;

            assign w_s0 = {1'b0, i_x[gi*BLKW +: BLKW]} + {1'b0, i_y[gi*BLKW +: BLKW]};
            assign w_s1 = {1'b0, i_x[gi*BLKW +: BLKW]} + {1'b0, i_y[gi*BLKW +: BLKW]}
                        + (BLKW+1)'(1);

            assign o_sum[gi*BLKW +: BLKW] = w_carry[gi] ? w_s1[BLKW-1:0] : w_s0[BLKW-1:0];
            assign w_carry[gi+1]          = w_carry[gi] ? w_s1[BLKW]     : w_s0[BLKW];
        end
    endgenerate

    assign o_sum[SUMW-1] = w_carry[NBLK];

endmodule

// File: rtl/rr_arb_nreq.sv
// ---------------------------------------------------------------------------
// rr_arb_nreq
// Combinational rotating-priority arbiter. The search starts at i_ptr+1
// (mod NREQ) and wraps; the first asserted request wins.
//   i_req        request vector
//   i_ptr        index of the last winner
//   o_grant      one-hot grant, all zero when no request
//   o_grant_idx  binary index of the winner (0 when no request)
// ---------------------------------------------------------------------------
module rr_arb_nreq #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_idx
);

    // w_cand[k] = (i_ptr + 1 + k) mod NREQ: the index examined at search
    // step k. One extra bit holds the unreduced sum (< 2*NREQ), so a single
    // conditional subtract gives the modulo even when NREQ is not a power of 2.
    logic [IDW-1:0] w_cand [NREQ];
    logic           w_found;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDW:0] w_raw;

            assign w_raw = {1'b0, i_ptr} + (IDW+1)'(gi + 1);
            assign w_cand[gi] = (w_raw >= (IDW+1)'(NREQ))
                              ? IDW'(w_raw - (IDW+1)'(NREQ))
                              : w_raw[IDW-1:0];
        end
    endgenerate

    always_comb begin
        w_found     = 1'b0;
        o_grant_idx = '0;
        o_grant     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && i_req[w_cand[k]]) begin
                w_found     = 1'b1;
                o_grant_idx = w_cand[k];
            end
        end
        if (w_found) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/csa_share_sched.sv
// ---------------------------------------------------------------------------
// csa_share_sched
// Shares one 25-bit carry-select adder among NREQ requesters. One operand
// pair is accepted per cycle by round-robin arbitration; the sum and the
// winner's ID are captured in a single output register with backpressure.
// A saturating counter records the number of accepted pairs.
//   clk        clock, all state on the rising edge
//   rst        synchronous reset, active-high
//   bus        csa_share_sched_if.slave: request and result handshakes
//   cnt_clr    clear the grant counter (wins over a coinciding transfer)
//   grant_cnt  accepted pairs since reset/clear, saturating at 2^CNTW-1
// ---------------------------------------------------------------------------
module csa_share_sched
    import csa_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst,
    csa_share_sched_if.slave   bus,
    input  logic               cnt_clr,
    output logic [CNTW-1:0]    grant_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [IDW-1:0]  PTR_INIT = IDW'(NREQ - 1);

    // Output stage and arbitration state
    logic               r_out_valid;
    logic [SUMW-1:0]    r_out_sum;
    logic [IDW-1:0]     r_out_id;
    logic [IDW-1:0]     r_ptr;
    logic [CNTW-1:0]    r_grant_cnt;

    logic [NREQ-1:0]    w_grant;
    logic [IDW-1:0]     w_grant_idx;
    logic [NREQ-1:0]    w_ready;
    logic               w_load_en;
    logic               w_xfer;
    op_pair_t           w_pairs [NREQ];
    op_pair_t           w_sel;
    logic [SUMW-1:0]    w_sum;
    logic [CNTW-1:0]    w_cnt_next;

    // The output register can take a new result when empty or being drained.
    assign w_load_en = !r_out_valid || bus.out_ready;

    rr_arb_nreq #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req       (bus.req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Ready is held off during reset so nothing is accepted that reset
    // would immediately throw away.
    assign w_ready = (w_load_en && !rst) ? w_grant : '0;
    assign w_xfer  = |w_ready;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_pairs[gi] = {bus.req_x[gi*OPW +: OPW], bus.req_y[gi*OPW +: OPW]};
        end
    endgenerate

    assign w_sel = w_pairs[w_grant_idx];

    UBCSe_24_0_24_0 u_add (
        .i_x   (w_sel.x),
        .i_y   (w_sel.y),
        .o_sum (w_sum)
    );

    // Clear takes precedence over counting; the count sticks at its maximum.
    always_comb begin
        w_cnt_next = r_grant_cnt;
        if (cnt_clr) begin
            w_cnt_next = '0;
        end else if (w_xfer && (r_grant_cnt != CNT_MAX)) begin
            w_cnt_next = r_grant_cnt + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_id    <= '0;
            r_ptr       <= PTR_INIT;
            r_grant_cnt <= '0;
        end else begin
            r_grant_cnt <= w_cnt_next;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_sum;
                r_out_id    <= w_grant_idx;
                r_ptr       <= w_grant_idx;
            end else if (bus.out_ready) begin
                // Drained with nothing to reload: data fields keep last value.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_id    = r_out_id;
    assign grant_cnt     = r_grant_cnt;

endmodule

// File: tb/tb_csa_share_sched.sv
// ---------------------------------------------------------------------------
// tb_csa_share_sched
// Directed test of csa_share_sched with a queue-based scoreboard: each test
// pushes the results it expects in the order arbitration should produce them,
// and an independent monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_csa_share_sched;
    import csa_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            cnt_clr;
    logic [CNTW-1:0] grant_cnt;

    csa_share_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    csa_share_sched #(
        .NREQ (NREQ),
        .IDW  (IDW),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0]  id;
        logic [SUMW-1:0] sum;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Per-requester pending operand pairs (FIFO by head/tail index)
    logic [OPW-1:0] pend_x [NREQ][DEPTH];
    logic [OPW-1:0] pend_y [NREQ][DEPTH];
    int             head   [NREQ];
    int             tail   [NREQ];

    int n_chk  = 0;
    int n_pass = 0;
    int acc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic add_pair(input int i, input logic [OPW-1:0] x, input logic [OPW-1:0] y);
        pend_x[i][tail[i]] = x;
        pend_y[i][tail[i]] = y;
        tail[i]++;
    endtask

    task automatic push_exp(input int i, input logic [OPW-1:0] x, input logic [OPW-1:0] y);
        exp_t e;
        e.id  = IDW'(i);
        e.sum = {1'b0, x} + {1'b0, y};
        exp_q.push_back(e);
    endtask

    task automatic refresh();
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] < tail[i]) begin
                bus.req_valid[i]           = 1'b1;
                bus.req_x[i*OPW +: OPW]    = pend_x[i][head[i]];
                bus.req_y[i*OPW +: OPW]    = pend_y[i][head[i]];
            end else begin
                bus.req_valid[i]           = 1'b0;
                bus.req_x[i*OPW +: OPW]    = '0;
                bus.req_y[i*OPW +: OPW]    = '0;
            end
        end
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() != 0);
        for (int i = 0; i < NREQ; i++) if (head[i] < tail[i]) b = 1'b1;
        return b;
    endfunction

    // One clock: sample the handshake mid-cycle, then retire accepted pairs
    // just after the edge and present the next operands.
    task automatic cycle();
        logic [NREQ-1:0] rdy;
        logic            legal;
        logic            in_rst;
        @(negedge clk);
        rdy    = bus.req_ready;
        in_rst = rst;
        legal  = ((rdy & ~bus.req_valid) == '0) && ($countones(rdy) <= 1)
              && (!in_rst || (rdy == '0));
        chk("ready_legal", {31'd0, legal}, 32'd1);
        @(posedge clk);
        #1;
        if (!in_rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rdy[i]) begin
                    head[i]++;
                    acc_cnt++;
                end
            end
        end
        refresh();
    endtask

    task automatic drain(input int max_cycles);
        for (int c = 0; c < max_cycles && busy(); c++) cycle();
        chk("drain_timeout", {31'd0, busy()}, 32'd0);
    endtask

    // Scoreboard monitor: a result leaves on every out_valid & out_ready edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output: got id=%0d sum=0x%0h, required no output",
                         bus.out_id, bus.out_sum);
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn id=%0d sum=0x%07h (expected id=%0d sum=0x%07h)",
                         bus.out_id, bus.out_sum, mon_e.id, mon_e.sum);
                chk("out_id",  32'(bus.out_id),  32'(mon_e.id));
                chk("out_sum", 32'(bus.out_sum), 32'(mon_e.sum));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        cnt_clr       = 1'b0;
        bus.out_ready = 1'b1;
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end

        // Reset state
        repeat (3) cycle();
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum",   32'(bus.out_sum),   32'd0);
        chk("rst_out_id",    32'(bus.out_id),    32'd0);
        chk("rst_grant_cnt", 32'(grant_cnt),     32'd0);

        // Single request: 5 + 7 visible right after the accepting edge
        add_pair(0, 25'd5, 25'd7);
        push_exp(0, 25'd5, 25'd7);
        refresh();
        cycle();
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_out_sum",   32'(bus.out_sum),   32'd12);
        chk("lat_out_id",    32'(bus.out_id),    32'd0);
        chk("lat_grant_cnt", 32'(grant_cnt),     32'd1);
        drain(10);

        // All four continuously valid after reset: ids 0,1,2,3 repeating,
        // one acceptance per cycle
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                add_pair(i, OPW'(i*4096 + k*333 + 11), OPW'(k*65536 + i*77 + 1));
                push_exp(i, OPW'(i*4096 + k*333 + 11), OPW'(k*65536 + i*77 + 1));
            end
        end
        refresh();
        acc_cnt = 0;
        repeat (12) cycle();
        chk("one_per_cycle", 32'(acc_cnt), 32'd12);
        drain(10);

        // Stall: last winner was 3, so req1 wins; then hold out_ready low
        bus.out_ready = 1'b0;
        add_pair(1, 25'd100, 25'd200);
        push_exp(1, 25'd100, 25'd200);
        refresh();
        cycle();
        add_pair(0, 25'h0ABCDE, 25'h012345);
        add_pair(2, 25'h1000000, 25'h0FFFFFF);
        add_pair(3, 25'd999, 25'd1);
        push_exp(2, 25'h1000000, 25'h0FFFFFF);
        push_exp(3, 25'd999, 25'd1);
        push_exp(0, 25'h0ABCDE, 25'h012345);
        refresh();
        for (int s = 0; s < 3; s++) begin
            cycle();
            chk("stall_ready",     32'(bus.req_ready), 32'd0);
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_out_id",    32'(bus.out_id),    32'd1);
            chk("stall_out_sum",   32'(bus.out_sum),   32'd300);
        end
        bus.out_ready = 1'b1;
        drain(10);

        // Arithmetic boundaries; last winner 0, so order is 1,3,0
        add_pair(0, 25'h1FFFFFF, 25'h1FFFFFF);
        add_pair(1, 25'h1FFFFFF, 25'h0000001);
        add_pair(3, 25'h0, 25'h0);
        push_exp(1, 25'h1FFFFFF, 25'h0000001);
        push_exp(3, 25'h0, 25'h0);
        push_exp(0, 25'h1FFFFFF, 25'h1FFFFFF);
        refresh();
        drain(10);

        // Reset with a pending result and requests outstanding
        bus.out_ready = 1'b0;
        add_pair(2, 25'h123, 25'h456);
        add_pair(3, 25'h10, 25'h20);
        refresh();
        cycle();
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_rst_id",    32'(bus.out_id),    32'd2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_grant_cnt", 32'(grant_cnt),     32'd0);
        bus.out_ready = 1'b1;
        add_pair(0, 25'd1, 25'd2);
        add_pair(1, 25'd3, 25'd4);
        push_exp(0, 25'd1, 25'd2);
        push_exp(1, 25'd3, 25'd4);
        push_exp(3, 25'h10, 25'h20);
        refresh();
        drain(10);
        chk("post_rst_cnt", 32'(grant_cnt), 32'd3);

        // Counter clear, then saturation at 15 after 20 transfers
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        chk("clr_idle", 32'(grant_cnt), 32'd0);
        for (int j = 0; j < 20; j++) begin
            add_pair(0, OPW'(j), OPW'(3*j));
            push_exp(0, OPW'(j), OPW'(3*j));
        end
        refresh();
        drain(40);
        chk("cnt_saturate", 32'(grant_cnt), 32'd15);

        // Clear coinciding with a transfer gives 0; the next transfer counts 1
        add_pair(1, 25'd7, 25'd8);
        push_exp(1, 25'd7, 25'd8);
        refresh();
        acc_cnt = 0;
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        chk("clr_xfer_accepted", 32'(acc_cnt),   32'd1);
        chk("clr_xfer_cnt",      32'(grant_cnt), 32'd0);
        add_pair(2, 25'd1, 25'd1);
        push_exp(2, 25'd1, 25'd1);
        refresh();
        drain(10);
        chk("cnt_after_clr", 32'(grant_cnt), 32'd1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
